// File: rtl/connect4_game_ctrl.sv
// Connect4 game engine: board, turns, move validation, turn timer, win/draw detection.
// Optional: define CONNECT4_AUTO_DROP_EN so a turn timeout plays the leftmost open column.
module connect4_game_ctrl #(
  parameter int unsigned TICKS_PER_SEC = 50_000_000,
  parameter int unsigned TURN_SECONDS  = 9
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [2:0]            col_sel,
  input  logic                  drop,
  output logic [1:0][5:0][6:0]  board,
  output logic [1:0]            game_state,
  output logic [1:0]            current_player,
  output logic [3:0]            turn_timer,
  output logic                  move_rejected
);

  localparam int unsigned     PW         = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [PW-1:0]   PRESC_MAX  = PW'(TICKS_PER_SEC - 1);
  localparam logic [3:0]      TIMER_INIT = 4'(TURN_SECONDS);

  typedef enum logic [2:0] {
    S_MENU,
    S_WAIT,
    S_PLACE,
    S_CHECK,
    S_WIN,
    S_DRAW
  } state_e;

  state_e        state_q, state_d;
  logic [1:0]    cell_q [0:5][0:6];
  logic [1:0]    cell_d [0:5][0:6];
  logic [1:0]    player_q, player_d;
  logic [3:0]    timer_q, timer_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [5:0]    moves_q, moves_d;
  logic [2:0]    row_q, row_d;
  logic [2:0]    col_q, col_d;
  logic          rej_q, rej_d;

  logic [2:0]    col_safe;
  logic [2:0]    land_row;
  logic          legal;
  logic          win;
  logic          tick;
  logic          timeout;

  function automatic logic [1:0] other(input logic [1:0] p);
    return (p == 2'b01) ? 2'b10 : 2'b01;
  endfunction

  always_comb begin
    col_safe = (col_sel <= 3'd6) ? col_sel : 3'd0;
    legal    = (col_sel <= 3'd6) && (cell_q[0][col_safe] == 2'b00);
    land_row = '0;
    for (int unsigned r = 0; r < 6; r++) begin
      if (cell_q[r][col_safe] == 2'b00) land_row = 3'(r);
    end
  end

`ifdef CONNECT4_AUTO_DROP_EN
  logic [2:0] auto_col;
  logic [2:0] auto_row;

  // Scan right-to-left so the last hit is the leftmost open column.
  always_comb begin
    auto_col = '0;
    for (int unsigned c = 7; c > 0; c--) begin
      if (cell_q[0][c-1] == 2'b00) auto_col = 3'(c - 1);
    end
    auto_row = '0;
    for (int unsigned r = 0; r < 6; r++) begin
      if (cell_q[r][auto_col] == 2'b00) auto_row = 3'(r);
    end
  end
`endif

  // Empty cells never equal player_q, so only the mover's tokens can match.
  always_comb begin
    win = 1'b0;
    for (int unsigned r = 0; r < 6; r++) begin
      for (int unsigned c = 0; c < 4; c++) begin
        if (cell_q[r][c] == player_q && cell_q[r][c+1] == player_q &&
            cell_q[r][c+2] == player_q && cell_q[r][c+3] == player_q) win = 1'b1;
      end
    end
    for (int unsigned r = 0; r < 3; r++) begin
      for (int unsigned c = 0; c < 7; c++) begin
        if (cell_q[r][c] == player_q && cell_q[r+1][c] == player_q &&
            cell_q[r+2][c] == player_q && cell_q[r+3][c] == player_q) win = 1'b1;
      end
    end
    for (int unsigned r = 0; r < 3; r++) begin
      for (int unsigned c = 0; c < 4; c++) begin
        if (cell_q[r][c] == player_q && cell_q[r+1][c+1] == player_q &&
            cell_q[r+2][c+2] == player_q && cell_q[r+3][c+3] == player_q) win = 1'b1;
        if (cell_q[r][c+3] == player_q && cell_q[r+1][c+2] == player_q &&
            cell_q[r+2][c+1] == player_q && cell_q[r+3][c] == player_q) win = 1'b1;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    cell_d   = cell_q;
    player_d = player_q;
    timer_d  = timer_q;
    presc_d  = presc_q;
    moves_d  = moves_q;
    row_d    = row_q;
    col_d    = col_q;
    rej_d    = 1'b0;
    tick     = (presc_q == PRESC_MAX);
    timeout  = 1'b0;

    case (state_q)
      S_MENU: ;
      S_WAIT: begin
        presc_d = tick ? '0 : presc_q + 1'b1;
        if (tick) begin
          if (timer_q != 4'd0) timer_d = timer_q - 4'd1;
          else                 timeout = 1'b1;
        end
        if (drop && legal) begin
          row_d   = land_row;
          col_d   = col_sel;
          state_d = S_PLACE;
        end else begin
          if (drop) rej_d = 1'b1;
          if (timeout) begin
`ifdef CONNECT4_AUTO_DROP_EN
            row_d   = auto_row;
            col_d   = auto_col;
            state_d = S_PLACE;
`else
            player_d = other(player_q);
            timer_d  = TIMER_INIT;
`endif
          end
        end
      end
      S_PLACE: begin
        cell_d[row_q][col_q] = player_q;
        moves_d              = moves_q + 6'd1;
        state_d              = S_CHECK;
      end
      S_CHECK: begin
        if (win) begin
          state_d = S_WIN;
        end else if (moves_q == 6'd42) begin
          state_d = S_DRAW;
        end else begin
          player_d = other(player_q);
          timer_d  = TIMER_INIT;
          presc_d  = '0;
          state_d  = S_WAIT;
        end
      end
      S_WIN, S_DRAW: ;
      default: state_d = S_MENU;
    endcase

    if (start) begin
      cell_d   = '{default: '0};
      moves_d  = '0;
      presc_d  = '0;
      player_d = 2'b01;
      timer_d  = TIMER_INIT;
      rej_d    = 1'b0;
      state_d  = S_WAIT;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_MENU;
      cell_q   <= '{default: '0};
      player_q <= 2'b01;
      timer_q  <= TIMER_INIT;
      presc_q  <= '0;
      moves_q  <= '0;
      row_q    <= '0;
      col_q    <= '0;
      rej_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cell_q   <= cell_d;
      player_q <= player_d;
      timer_q  <= timer_d;
      presc_q  <= presc_d;
      moves_q  <= moves_d;
      row_q    <= row_d;
      col_q    <= col_d;
      rej_q    <= rej_d;
    end
  end

  // board is bit-plane packed: board[b][r][c] is bit b of cell (r,c).
  for (genvar r = 0; r < 6; r++) begin : g_row
    for (genvar c = 0; c < 7; c++) begin : g_col
      assign board[0][r][c] = cell_q[r][c][0];
      assign board[1][r][c] = cell_q[r][c][1];
    end
  end

  always_comb begin
    game_state = 2'b01;
    case (state_q)
      S_MENU:  game_state = 2'b00;
      S_WIN:   game_state = 2'b10;
      S_DRAW:  game_state = 2'b11;
      default: ;
    endcase
  end

  assign current_player = player_q;
  assign turn_timer     = timer_q;
  assign move_rejected  = rej_q;

endmodule
